// File: rtl/mem_access_stage.sv
// MEM pipeline stage in front of the 32-word byte-writable data RAM: drives address,
// byte enables and aligned store data, extends load data and hands results to WB.
// Optional macro MEM_ALIGN_CHECK_EN adds misaligned halfword/word address exceptions.
module mem_access_stage #(
  parameter int LOAD_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  output logic        mem_allow_in,
  input  logic [3:0]  exe_mem_op,
  input  logic [31:0] exe_result,
  input  logic [31:0] exe_store_data,
  input  logic [4:0]  exe_rd,
  input  logic        exe_rf_wen,
  input  logic        wb_allow_in,
  output logic        mem_valid_out,
  output logic [31:0] mem_result,
  output logic [4:0]  mem_rd,
  output logic        mem_rf_wen,
  output logic        mem_exc,
  output logic [3:0]  dm_wen,
  output logic [4:0]  dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);
  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
    OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8
  } op_e;

  localparam logic [2:0] WAIT_C = 3'(LOAD_WAIT);

  logic        mem_v;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic [4:0]  rd;
  logic        rf_wen;
  logic [2:0]  cnt;
  logic        st_done;

  logic is_load, is_store, exc, mem_done, capture;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  assign is_load  = (op >= OP_LB) && (op <= OP_LW);
  assign is_store = (op >= OP_SB) && (op <= OP_SW);

`ifdef MEM_ALIGN_CHECK_EN
  assign exc = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0]) ||
               (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00));
`else
  assign exc = 1'b0;
`endif

  // A faulting load has nothing to wait for, so it completes at once.
  assign mem_done      = is_load ? (exc || (cnt == WAIT_C)) : 1'b1;
  assign mem_valid_out = mem_v & mem_done;
  assign mem_allow_in  = !mem_v | (mem_done & wb_allow_in);
  assign capture       = exe_valid & mem_allow_in;

  assign mem_rd     = rd;
  assign mem_rf_wen = rf_wen & !exc;
  assign mem_exc    = mem_valid_out & exc;
  assign dm_addr    = addr[6:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_v   <= 1'b0;
      op      <= '0;
      addr    <= '0;
      sdata   <= '0;
      rd      <= '0;
      rf_wen  <= 1'b0;
      cnt     <= '0;
      st_done <= 1'b0;
    end else if (capture) begin
      mem_v   <= 1'b1;
      op      <= exe_mem_op;
      addr    <= exe_result;
      sdata   <= exe_store_data;
      rd      <= exe_rd;
      rf_wen  <= exe_rf_wen;
      cnt     <= '0;
      st_done <= 1'b0;
    end else begin
      if (mem_valid_out && wb_allow_in) mem_v <= 1'b0;
      if (mem_v && is_load && (cnt != WAIT_C)) cnt <= cnt + 3'd1;
      // Once the write has been issued it must not repeat while WB stalls.
      if (mem_v && is_store) st_done <= 1'b1;
    end
  end

  always_comb begin
    dm_wen = 4'b0000;
    if (mem_v && !st_done && !exc) begin
      case (op)
        OP_SB:   dm_wen = 4'b0001 << addr[1:0];
        OP_SH:   dm_wen = addr[1] ? 4'b1100 : 4'b0011;
        OP_SW:   dm_wen = 4'b1111;
        default: dm_wen = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_SB:   dm_wdata = {4{sdata[7:0]}};
      OP_SH:   dm_wdata = {2{sdata[15:0]}};
      default: dm_wdata = sdata;
    endcase
  end

  always_comb begin
    case (addr[1:0])
      2'd0:    lbyte = dm_rdata[7:0];
      2'd1:    lbyte = dm_rdata[15:8];
      2'd2:    lbyte = dm_rdata[23:16];
      default: lbyte = dm_rdata[31:24];
    endcase
    lhalf = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op)
      OP_LB:   mem_result = {{24{lbyte[7]}}, lbyte};
      OP_LBU:  mem_result = {24'd0, lbyte};
      OP_LH:   mem_result = {{16{lhalf[15]}}, lhalf};
      OP_LHU:  mem_result = {16'd0, lhalf};
      OP_LW:   mem_result = dm_rdata;
      default: mem_result = addr;
    endcase
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: table of instructions fed through a scoreboard, with a
// byte-writable RAM model, plus stall, back-to-back and reset-mid-load sequences.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid, mem_allow_in;
  logic [3:0]  exe_mem_op;
  logic [31:0] exe_result, exe_store_data;
  logic [4:0]  exe_rd;
  logic        exe_rf_wen, wb_allow_in;
  logic        mem_valid_out;
  logic [31:0] mem_result;
  logic [4:0]  mem_rd;
  logic        mem_rf_wen, mem_exc;
  logic [3:0]  dm_wen;
  logic [4:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;

  mem_access_stage #(.LOAD_WAIT(1)) dut (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .mem_allow_in(mem_allow_in),
    .exe_mem_op(exe_mem_op), .exe_result(exe_result), .exe_store_data(exe_store_data),
    .exe_rd(exe_rd), .exe_rf_wen(exe_rf_wen), .wb_allow_in(wb_allow_in),
    .mem_valid_out(mem_valid_out), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_rf_wen(mem_rf_wen), .mem_exc(mem_exc), .dm_wen(dm_wen), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rfw;
    logic [31:0] eres;
    logic        erfw;
    logic        eexc;
    logic [3:0]  ewen;
    logic [31:0] ewd;
    logic        cwd;
    int          elat;
    int          cyc;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[14];
  int   npass = 0, nchk = 0, nwr = 0, cyc = 0;
  logic ram_clr;
  logic [31:0] ram [32];

  assign dm_rdata = ram[dm_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) ram[i] <= 32'd0;
      ram[4] <= 32'h80FF_7F01;
    end else begin
      for (int b = 0; b < 4; b++)
        if (dm_wen[b]) ram[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) if (dm_wen != 4'd0) nwr++;

  // Scoreboard: every WB hand-off must match the oldest outstanding instruction.
  always @(negedge clk) begin
    if (!rst && mem_valid_out && wb_allow_in) begin
      if (sb.size() == 0) chk("unexpected_valid", {31'd0, mem_valid_out}, 32'd0);
      else begin
        vec_t e;
        e = sb.pop_front();
        chk("result", mem_result, e.eres);
        chk("rd", 32'(mem_rd), 32'(e.rd));
        chk("rf_wen", 32'(mem_rf_wen), 32'(e.erfw));
        chk("exc", 32'(mem_exc), 32'(e.eexc));
        chk("dm_wen", 32'(dm_wen), 32'(e.ewen));
        chk("dm_addr", 32'(dm_addr), 32'(e.res[6:2]));
        if (e.cwd) chk("dm_wdata", dm_wdata, e.ewd);
        if (e.elat != 0) chk("latency", cyc - e.cyc, e.elat);
      end
    end
  end

  task automatic send(input vec_t v, output int waited);
    exe_valid = 1'b1;
    exe_mem_op = v.op; exe_result = v.res; exe_store_data = v.sd;
    exe_rd = v.rd; exe_rf_wen = v.rfw;
    waited = 0;
    @(negedge clk);
    while (!mem_allow_in && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!mem_allow_in) chk("allow_in_timeout", 32'(mem_allow_in), 32'd1);
    v.cyc = cyc;
    sb.push_back(v);
    @(posedge clk); #1;
    exe_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] res, input logic [31:0] sd,
                              input logic [4:0] rd, input logic rfw, input logic [31:0] eres,
                              input logic erfw, input logic eexc, input logic [3:0] ewen,
                              input logic [31:0] ewd, input logic cwd, input int elat);
    vec_t v;
    v.op = op; v.res = res; v.sd = sd; v.rd = rd; v.rfw = rfw; v.eres = eres;
    v.erfw = erfw; v.eexc = eexc; v.ewen = ewen; v.ewd = ewd; v.cwd = cwd;
    v.elat = elat; v.cyc = 0;
    return v;
  endfunction

  initial begin
    int w, wr0;
    vec_t v;
    tbl[0]  = mk(4'd0, 32'h1234_5678, 32'h0, 5'd3, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1);
    tbl[1]  = mk(4'd1, 32'h12, 32'h0, 5'd4, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 2);
    tbl[2]  = mk(4'd2, 32'h12, 32'h0, 5'd5, 1'b1, 32'h0000_00FF, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 2);
    tbl[3]  = mk(4'd3, 32'h12, 32'h0, 5'd6, 1'b1, 32'hFFFF_80FF, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 2);
    tbl[4]  = mk(4'd4, 32'h10, 32'h0, 5'd7, 1'b1, 32'h0000_7F01, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 2);
    tbl[5]  = mk(4'd5, 32'h10, 32'h0, 5'd8, 1'b1, 32'h80FF_7F01, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 2);
    tbl[6]  = mk(4'd6, 32'h13, 32'hA5, 5'd0, 1'b0, 32'h13, 1'b0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 1'b1, 1);
    tbl[7]  = mk(4'd5, 32'h10, 32'h0, 5'd9, 1'b1, 32'hA5FF_7F01, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 2);
    tbl[8]  = mk(4'd8, 32'h20, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h20, 1'b0, 1'b0, 4'hF, 32'hCAFE_F00D, 1'b1, 1);
    tbl[9]  = mk(4'd5, 32'h20, 32'h0, 5'd10, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 2);
`ifdef MEM_ALIGN_CHECK_EN
    tbl[10] = mk(4'd7, 32'h05, 32'h1234_BEEF, 5'd11, 1'b1, 32'h05, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 1);
`else
    tbl[10] = mk(4'd7, 32'h05, 32'h1234_BEEF, 5'd11, 1'b1, 32'h05, 1'b1, 1'b0, 4'b0011, 32'hBEEF_BEEF, 1'b1, 1);
`endif
    tbl[11] = mk(4'd12, 32'h55AA, 32'h0, 5'd12, 1'b1, 32'h55AA, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1);
    tbl[12] = mk(4'd7, 32'h06, 32'h0000_1234, 5'd0, 1'b0, 32'h06, 1'b0, 1'b0, 4'b1100, 32'h1234_1234, 1'b1, 1);
    tbl[13] = mk(4'd3, 32'h06, 32'h0, 5'd13, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 2);

    rst = 1'b1; ram_clr = 1'b1; exe_valid = 1'b0; wb_allow_in = 1'b1;
    exe_mem_op = '0; exe_result = '0; exe_store_data = '0; exe_rd = '0; exe_rf_wen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; ram_clr = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(mem_valid_out), 32'd0);
    chk("rst_allow_in", 32'(mem_allow_in), 32'd1);
    chk("rst_wen", 32'(dm_wen), 32'd0);
    chk("rst_exc", 32'(mem_exc), 32'd0);
    chk("rst_result", mem_result, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) send(tbl[i], w);
    repeat (3) @(negedge clk);
    chk("table_drained", sb.size(), 32'd0);

    // Back-to-back ALU ops: MEM must never refuse one.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      v = mk(4'd0, 32'hA000_0000 + i * 32'h0101_0101, 32'h0, 5'(i + 1), 1'b1,
             32'hA000_0000 + i * 32'h0101_0101, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1);
      send(v, w);
      chk("alu_waited", w, 32'd0);
    end
    repeat (2) @(negedge clk);
    chk("alu_drained", sb.size(), 32'd0);

    // SW under a 5-cycle WB stall: one write only, stage blocked until release.
    @(posedge clk); #1;
    wb_allow_in = 1'b0;
    wr0 = nwr;
    v = mk(4'd8, 32'h08, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h08, 1'b0, 1'b0, 4'h0, 32'hDEAD_BEEF, 1'b1, 0);
    send(v, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wen", 32'(dm_wen), (i == 0) ? 32'hF : 32'h0);
      chk("stall_allow_in", 32'(mem_allow_in), 32'd0);
      chk("stall_valid", 32'(mem_valid_out), 32'd1);
    end
    @(posedge clk); #1;
    wb_allow_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall_writes", nwr - wr0, 32'd1);
    chk("stall_ram", ram[2], 32'hDEAD_BEEF);
    chk("stall_drained", sb.size(), 32'd0);

    // Reset while a load waits: it must vanish without ever going valid.
    @(posedge clk); #1;
    v = mk(4'd5, 32'h10, 32'h0, 5'd14, 1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 0);
    send(v, w);
    void'(sb.pop_back());
    chk("wait_valid", 32'(mem_valid_out), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstload_valid", 32'(mem_valid_out), 32'd0);
    chk("rstload_allow_in", 32'(mem_allow_in), 32'd1);
    chk("rstload_wen", 32'(dm_wen), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rstload_quiet", 32'(mem_valid_out), 32'd0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access (MEM) pipeline stage placed directly upstream of the 32-word data RAM (4-bit byte write enable, 5-bit word address, 32-bit write data, asynchronous read).
- Latches one EXE-stage instruction and drives RAM address, byte enables and aligned store data.
- Extracts and extends load data, then hands a result to WB over a valid/allow-in handshake.

Parameters:
- LOAD_WAIT, 1, extra cycles a load stays in MEM before its result is valid (0..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exe_valid  in  1  EXE presents an instruction
- mem_allow_in  out  1  MEM accepts the instruction this cycle
- exe_mem_op  in  4  0 NOP/ALU, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9..15 treated as NOP
- exe_result  in  32  ALU result; byte address for memory ops
- exe_store_data  in  32  rt value for stores
- exe_rd  in  5  destination register
- exe_rf_wen  in  1  instruction writes the register file
- wb_allow_in  in  1  WB accepts
- mem_valid_out  out  1  result valid to WB
- mem_result  out  32  load data or passed-through exe_result
- mem_rd  out  5  latched exe_rd
- mem_rf_wen  out  1  latched exe_rf_wen, gated by exception
- mem_exc  out  1  address exception (see Optional Feature)
- dm_wen  out  4  RAM byte write enables
- dm_addr  out  5  RAM word address = latched address[6:2]
- dm_wdata  out  32  RAM aligned write data
- dm_rdata  in  32  RAM read data (combinational)

Behaviour:
- The stage has one instruction register holding: mem_v, op, addr, sdata, rd, rf_wen, cnt[2:0], st_done.
- Reset: mem_v=0, cnt=0, st_done=0. The outputs are therefore mem_valid_out=0, dm_wen=0, mem_allow_in=1 and mem_exc=0. Data registers are cleared to 0.
- mem_done:
  - Loads: mem_done = (cnt==LOAD_WAIT).
  - All other ops: mem_done = 1.
  - A load with an exception: mem_done = 1.
- mem_allow_in = !mem_v | (mem_done & wb_allow_in). It is combinational.
- Capture: on a clk edge with exe_valid & mem_allow_in, the stage loads all fields and sets mem_v=1, cnt=0, st_done=0.
- Drain: on a clk edge with mem_valid_out & wb_allow_in and no new capture, mem_v goes to 0. Back-to-back capture and drain in the same edge is permitted with no bubble.
- cnt increments while mem_v and the op is a load and cnt<LOAD_WAIT, then saturates.
- mem_valid_out = mem_v & mem_done.
- dm_addr is driven from addr[6:2] at all times. It is stable for the whole residency.
- Stores:
  - dm_wen is nonzero only when mem_v & store & !st_done & !exc.
  - st_done sets on the next edge, so exactly one write occurs per store even if WB stalls.
  - Reset during a store with the write already issued does not undo the write.
  - SB: dm_wdata={4{sdata[7:0]}}, dm_wen=4'b0001<<addr[1:0].
  - SH: dm_wdata={2{sdata[15:0]}}, dm_wen = addr[1] ? 4'b1100 : 4'b0011.
  - SW: dm_wdata=sdata, dm_wen=4'b1111.
- Loads (mem_result from dm_rdata):
  - LB/LBU: byte addr[1:0], sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: full word.
- Non-loads: mem_result = latched exe_result. Stores and NOP pass through; rf_wen comes from the decoder.
- A store followed immediately by a load to the same word: the load captures on the edge the store write commits, so it reads the new data. No forwarding is required.
- Reset mid-load: the instruction is dropped and mem_valid_out does not assert.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, sets exc.
  - When exc is set: dm_wen=0, mem_rf_wen=0, and mem_exc=1 together with mem_valid_out.
  - The load completes immediately, without the LOAD_WAIT wait.
- Undefined:
  - addr[0] is ignored for halfwords and addr[1:0] is ignored for words.
  - mem_exc is tied to 0 and no exception logic exists.

Test Plan:
- SB addr=0x0000_0013, sdata=0x0000_00A5 → dm_addr=4, dm_wen=4'b1000 for exactly 1 cycle, dm_wdata=0xA5A5A5A5; mem_valid_out=1 the same cycle.
- RAM word 4=0x80FF_7F01 with LOAD_WAIT=1; LB 0x12, LBU 0x12, LH 0x12, LHU 0x10, LW 0x10 → results 0xFFFFFFFF, 0x000000FF, 0xFFFF80FF, 0x00007F01, 0x80FF7F01. Each mem_valid_out rises 1 cycle after capture.
- SW 0x08, data 0xDEADBEEF, with wb_allow_in=0 for 5 cycles → dm_wen=4'hF only in the first cycle, mem_allow_in=0 until release, exactly one RAM write.
- Back-to-back ALU ops with wb_allow_in=1, LOAD_WAIT=0 → one result per cycle, mem_allow_in constantly 1, exe_result passed through unchanged.
- rst asserted during a load's wait cycle → next cycle mem_valid_out=0, mem_allow_in=1, dm_wen=0.
- With MEM_ALIGN_CHECK_EN, SH at 0x05 → mem_exc=1, dm_wen=0, mem_rf_wen=0. Without the macro → dm_wen=4'b0011 at word 1.
